sdr_wb_bist: RTL and testbench

SDR_WB_BIST -- requirements
Module: sdr_wb_bist

---
 rtl/sdr_bist_pkg.sv | 30 +++
 rtl/sdr_bist_lfsr.sv | 30 +++
 rtl/sdr_wb_bist.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_sdr_wb_bist.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_bist_pkg.sv
// rtl/sdr_bist_pkg.sv - shared types and constants for the SDRAM Wishbone BIST
// Holds the sequencer state encoding, the LFSR seed and tap mask, the
// pattern-select codes and the watchdog limit, plus the LFSR step function.
package sdr_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_REQ,
        ST_WR_GAP,
        ST_RD_REQ,
        ST_RD_GAP,
        ST_DONE
    } bist_state_e;

    // Galois form of x^32 + x^22 + x^2 + x + 1, shifting towards bit 0.
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic PAT_INC  = 1'b0;
    localparam logic PAT_LFSR = 1'b1;

    // Stall cycles (stb high, no ack) tolerated before the run is abandoned.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/sdr_bist_lfsr.sv
// rtl/sdr_bist_lfsr.sv - 32-bit Galois LFSR used as the BIST data generator
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset, reseeds the register
//   load_i     reseed on the next edge (takes priority over advance_i)
//   advance_i  step the register once on the next edge
//   value_o    current LFSR state
module sdr_bist_lfsr
    import sdr_bist_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        advance_i,
    output logic [31:0] value_o
);

    logic [31:0] value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            value_q <= LFSR_SEED;
        end else if (advance_i) begin
            value_q <= lfsr_next(value_q);
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/sdr_wb_bist.sv
// rtl/sdr_wb_bist.sv - Wishbone write/readback memory test master for an SDRAM controller
// Writes num_words words from base_addr with an incrementing or LFSR pattern,
// reads them back, counts mismatches and records the first failing address.
// Optional macro SDR_BIST_TIMEOUT_EN adds a per-access stall watchdog.
// Ports:
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   sdr_init_done_i                 SDRAM controller ready
//   start_i, base_addr_i,
//   num_words_i, pattern_sel_i      test request and its parameters
//   wb_cyc_o .. wb_cti_o, wb_ack_i,
//   wb_dat_i                        Wishbone classic-cycle master
//   busy_o, done_o, pass_o,
//   timeout_o, err_cnt_o,
//   first_err_addr_o                status and error report
module sdr_wb_bist
    import sdr_bist_pkg::*;
#(
    parameter int APP_AW = 26,
    parameter int DW     = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done_i,
    input  logic              start_i,
    input  logic [APP_AW-1:0] base_addr_i,
    input  logic [15:0]       num_words_i,
    input  logic              pattern_sel_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [15:0]       err_cnt_o,
    output logic [APP_AW-1:0] first_err_addr_o
);

    localparam int BW = DW / 8;
    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(BW);

    bist_state_e       state_q;
    logic [APP_AW-1:0] base_q;
    logic [15:0]       num_q;
    logic              pat_q;
    logic [15:0]       idx_q;

    logic              cyc_q, stb_q, we_q;
    logic [APP_AW-1:0] addr_q;
    logic [DW-1:0]     dat_q;
    logic [BW-1:0]     sel_q;
    logic              busy_q, done_q, pass_q;
    logic [15:0]       err_cnt_q;
    logic [APP_AW-1:0] first_err_q;

    logic [31:0]       lfsr_value;
    logic              lfsr_load;
    logic              lfsr_adv;
    logic              last_word;
    logic              in_req;

`ifdef SDR_BIST_TIMEOUT_EN
    logic [7:0]        wdog_q;
    logic              timeout_q;
    logic              wdog_hit;
    assign wdog_hit = (wdog_q == TIMEOUT_LIMIT - 8'd1);
`endif

    function automatic logic [DW-1:0] pattern_word(input logic sel,
                                                   input logic [15:0] idx,
                                                   input logic [31:0] lfsr);
        if (sel == PAT_INC) begin
            return DW'(idx);
        end
        return DW'(lfsr);
    endfunction

    // idx_q is bumped on each ack, so in a gap state it equals the number of
    // words already transferred in that phase.
    assign last_word = (idx_q == num_q);
    assign in_req    = (state_q == ST_WR_REQ) || (state_q == ST_RD_REQ);

    // The generator is reseeded when a test starts and again at the
    // write-to-read turnaround so the read phase regenerates the same words.
    assign lfsr_load = ((state_q == ST_IDLE) && start_i) ||
                       ((state_q == ST_WR_GAP) && last_word);
    assign lfsr_adv  = in_req && wb_ack_i;

    sdr_bist_lfsr u_lfsr (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .load_i    (lfsr_load),
        .advance_i (lfsr_adv),
        .value_o   (lfsr_value)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            pat_q       <= 1'b0;
            idx_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
`ifdef SDR_BIST_TIMEOUT_EN
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q      <= base_addr_i;
                        num_q       <= num_words_i;
                        pat_q       <= pattern_sel_i;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
`ifdef SDR_BIST_TIMEOUT_EN
                        wdog_q      <= '0;
                        timeout_q   <= 1'b0;
`endif
                        state_q     <= ST_WAIT_INIT;
                    end
                end

                ST_WAIT_INIT: begin
                    if (sdr_init_done_i) begin
                        if (num_q == 16'd0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            sel_q   <= '1;
                            addr_q  <= base_q;
                            dat_q   <= pattern_word(pat_q, idx_q, lfsr_value);
                            state_q <= ST_WR_REQ;
                        end
                    end
                end

                ST_WR_REQ: begin
                    if (wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        idx_q   <= idx_q + 16'd1;
`ifdef SDR_BIST_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                        state_q <= ST_WR_GAP;
                    end
`ifdef SDR_BIST_TIMEOUT_EN
                    else if (wdog_hit) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= '0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        wdog_q    <= wdog_q + 8'd1;
                    end
`endif
                end

                ST_WR_GAP: begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    sel_q <= '1;
                    if (last_word) begin
                        idx_q   <= '0;
                        we_q    <= 1'b0;
                        addr_q  <= base_q;
                        dat_q   <= '0;
                        state_q <= ST_RD_REQ;
                    end else begin
                        we_q    <= 1'b1;
                        addr_q  <= addr_q + ADDR_STEP;
                        dat_q   <= pattern_word(pat_q, idx_q, lfsr_value);
                        state_q <= ST_WR_REQ;
                    end
                end

                ST_RD_REQ: begin
                    if (wb_ack_i) begin
                        if (wb_dat_i != pattern_word(pat_q, idx_q, lfsr_value)) begin
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                            if (err_cnt_q == 16'd0) begin
                                first_err_q <= addr_q;
                            end
                        end
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        sel_q   <= '0;
                        idx_q   <= idx_q + 16'd1;
`ifdef SDR_BIST_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                        state_q <= ST_RD_GAP;
                    end
`ifdef SDR_BIST_TIMEOUT_EN
                    else if (wdog_hit) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        sel_q     <= '0;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        wdog_q    <= wdog_q + 8'd1;
                    end
`endif
                end

                ST_RD_GAP: begin
                    if (last_word) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == 16'd0);
                        state_q <= ST_DONE;
                    end else begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= '1;
                        addr_q  <= addr_q + ADDR_STEP;
                        state_q <= ST_RD_REQ;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o         = cyc_q;
    assign wb_stb_o         = stb_q;
    assign wb_we_o          = we_q;
    assign wb_addr_o        = addr_q;
    assign wb_dat_o         = dat_q;
    assign wb_sel_o         = sel_q;
    assign wb_cti_o         = 3'b000;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;

`ifdef SDR_BIST_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sdr_wb_bist.sv
// tb/tb_sdr_wb_bist.sv - self-checking bench for sdr_wb_bist with a Wishbone memory responder
module tb_sdr_wb_bist;

    logic        clk = 1'b0;
    logic        wb_rst;
    logic        init_done;
    logic        start;
    logic [25:0] base_addr;
    logic [15:0] num_words;
    logic        pattern_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic [25:0] wb_addr;
    logic [31:0] wb_wdat;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;
    logic [25:0] first_err;

    int vectors     = 0;
    int miscompares = 0;

    // Responder state and transaction logs
    logic [31:0] mem [logic [25:0]];
    logic [25:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [25:0] rd_addr_q [$];
    int          corrupt_idx = -1;
    int          lat_cnt     = 0;
    bit          stall_all   = 1'b0;
    bit          stray_en    = 1'b0;
    bit          cyc_seen    = 1'b0;
    bit          sel_bad     = 1'b0;

    always #5 clk = ~clk;

    sdr_wb_bist dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (wb_rst),
        .sdr_init_done_i  (init_done),
        .start_i          (start),
        .base_addr_i      (base_addr),
        .num_words_i      (num_words),
        .pattern_sel_i    (pattern_sel),
        .wb_cyc_o         (wb_cyc),
        .wb_stb_o         (wb_stb),
        .wb_we_o          (wb_we),
        .wb_addr_o        (wb_addr),
        .wb_dat_o         (wb_wdat),
        .wb_sel_o         (wb_sel),
        .wb_cti_o         (wb_cti),
        .wb_ack_i         (wb_ack),
        .wb_dat_i         (wb_rdat),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .timeout_o        (timeout),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        // Galois step for x^32 + x^22 + x^2 + x + 1
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: one-cycle ack after a random 0..2 cycle latency,
    // optional stray acks while stb is low, optional corruption of one read.
    initial begin
        int idx;
        wb_ack  = 1'b0;
        wb_rdat = '0;
        forever begin
            tick();
            if (wb_cyc) cyc_seen = 1'b1;
            if (wb_cyc && (wb_sel != 4'hF || wb_cti != 3'b000)) sel_bad = 1'b1;
            if (wb_ack) begin
                wb_ack = 1'b0;
            end else if (wb_cyc && wb_stb && !stall_all) begin
                if (lat_cnt == 0) begin
                    wb_ack  = 1'b1;
                    lat_cnt = $urandom_range(0, 2);
                    if (wb_we) begin
                        wr_addr_q.push_back(wb_addr);
                        wr_data_q.push_back(wb_wdat);
                        mem[wb_addr] = wb_wdat;
                    end else begin
                        idx = rd_addr_q.size();
                        rd_addr_q.push_back(wb_addr);
                        wb_rdat = mem.exists(wb_addr) ? mem[wb_addr] : 32'hDEAD_BEEF;
                        if (idx == corrupt_idx) wb_rdat = wb_rdat ^ 32'h0000_0100;
                    end
                end else begin
                    lat_cnt--;
                end
            end else if (stray_en && !wb_stb && ($urandom_range(0, 3) == 0)) begin
                wb_ack = 1'b1;
            end
        end
    end

    task automatic run_test(input string tag, input logic [25:0] base, input logic [15:0] n,
                            input logic pat, input int corrupt, input int init_delay,
                            input bit glitch);
        int          cycles;
        bit          got;
        logic [31:0] lf;
        logic [25:0] exp_a;
        logic [31:0] exp_d;
        bit          hit;
        logic [25:0] exp_first;

        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        cyc_seen    = 1'b0;
        sel_bad     = 1'b0;
        corrupt_idx = corrupt;
        if (init_delay > 0) init_done = 1'b0;

        base_addr   = base;
        num_words   = n;
        pattern_sel = pat;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        // Scramble the request inputs: the DUT must use its captured copies.
        base_addr   = 26'($urandom);
        num_words   = 16'($urandom);
        pattern_sel = 1'($urandom);
        check({tag, ".busy_after_start"}, busy, 1);
        check({tag, ".done_after_start"}, done, 0);

        if (init_delay > 0) begin
            repeat (init_delay) tick();
            check({tag, ".cyc_while_init_low"}, wb_cyc, 0);
            init_done = 1'b1;
        end

        cycles = 1;
        got    = 1'b0;
        while (!got && cycles < 20 * int'(n) + 60) begin
            tick();
            cycles++;
            start = glitch && busy && (cycles == 4);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, ".done_reached"}, got, 1);
        if (n == 16'd0) check({tag, ".zero_len_latency_ok"}, (cycles <= 3), 1);

        check({tag, ".write_count"}, wr_addr_q.size(), n);
        check({tag, ".read_count"}, rd_addr_q.size(), n);

        lf = 32'hACE1_2468;
        for (int k = 0; k < int'(n); k++) begin
            exp_a = base + 26'(4 * k);
            exp_d = pat ? lf : 32'(k);
            if (k < wr_addr_q.size()) begin
                check({tag, ".wr_addr"}, wr_addr_q[k], exp_a);
                check({tag, ".wr_data"}, wr_data_q[k], exp_d);
            end
            if (k < rd_addr_q.size()) check({tag, ".rd_addr"}, rd_addr_q[k], exp_a);
            lf = lfsr_step(lf);
        end

        hit       = (corrupt >= 0) && (corrupt < int'(n));
        exp_first = hit ? (base + 26'(4 * corrupt)) : 26'd0;
        check({tag, ".err_cnt"}, err_cnt, hit ? 1 : 0);
        check({tag, ".first_err_addr"}, first_err, exp_first);
        check({tag, ".pass"}, pass, !hit);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".timeout"}, timeout, 0);
        check({tag, ".cyc_seen"}, cyc_seen, (n != 16'd0));
        check({tag, ".sel_cti_classic"}, sel_bad, 0);

        // DONE falls back to IDLE with the status held.
        tick();
        check({tag, ".done_held"}, done, 1);
        check({tag, ".pass_held"}, pass, !hit);
        tick();
    endtask

    initial begin
        int  cycles;
        bit  found;

        wb_rst      = 1'b1;
        init_done   = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_words   = '0;
        pattern_sel = 1'b0;
        repeat (3) tick();

        check("rst.cyc", wb_cyc, 0);
        check("rst.stb", wb_stb, 0);
        check("rst.we", wb_we, 0);
        check("rst.addr", wb_addr, 0);
        check("rst.dat", wb_wdat, 0);
        check("rst.sel", wb_sel, 0);
        check("rst.cti", wb_cti, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.timeout", timeout, 0);
        check("rst.err_cnt", err_cnt, 0);
        check("rst.first_err", first_err, 0);
        wb_rst = 1'b0;
        tick();

        run_test("inc16", 26'h0, 16'd16, 1'b0, -1, 4, 1'b0);
        run_test("lfsr4", 26'h40, 16'd4, 1'b1, -1, 0, 1'b0);
        check("lfsr4.first_word_seed", wr_data_q[0], 32'hACE1_2468);
        run_test("zero_len", 26'h80, 16'd0, 1'b0, -1, 0, 1'b0);
        run_test("corrupt5", 26'h100, 16'd8, 1'b0, 5, 0, 1'b0);
        run_test("wrap", 26'h3FF_FFF8, 16'd5, 1'b1, 3, 0, 1'b0);

        // Reset in the middle of the write phase.
        base_addr   = 26'h80;
        num_words   = 16'd16;
        pattern_sel = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        cycles = 0;
        while (!found && cycles < 50) begin
            tick();
            cycles++;
            if (wb_stb && wb_we && cycles > 6) found = 1'b1;
        end
        check("midrst.in_write", found, 1);
        wb_rst = 1'b1;
        tick();
        wb_rst = 1'b0;
        check("midrst.cyc", wb_cyc, 0);
        check("midrst.stb", wb_stb, 0);
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        repeat (2) tick();
        run_test("after_rst", 26'h2000, 16'd6, 1'b1, -1, 0, 1'b0);

        // Randomised runs with stray acks and ignored mid-run start pulses.
        stray_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            logic [25:0] b;
            logic [15:0] nn;
            int          c;
            b  = 26'($urandom) & 26'h3FF_FFFC;
            nn = 16'($urandom_range(1, 40));
            c  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(nn) - 1)) : -1;
            run_test("rand", b, nn, 1'($urandom_range(0, 1)), c, int'($urandom_range(0, 2)), 1'b1);
        end
        stray_en = 1'b0;

`ifdef SDR_BIST_TIMEOUT_EN
        stall_all   = 1'b1;
        base_addr   = 26'h0;
        num_words   = 16'd3;
        pattern_sel = 1'b0;
        start       = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        found  = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            if (wb_stb) cycles++;
            if (done) found = 1'b1;
            else tick();
        end
        check("tmo.done", done, 1);
        check("tmo.timeout", timeout, 1);
        check("tmo.pass", pass, 0);
        check("tmo.stall_cycles", cycles, 255);
        check("tmo.cyc", wb_cyc, 0);
        stall_all = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: observed still running expected finished");
        $fatal(1);
    end

endmodule
